// File: rtl/mc_cpu_core.sv
// Multicycle MIPS-32 subset core with unified word memory, program-load port,
// debug register read, HALT/illegal trapping and a retired-instruction counter.
module mc_cpu_core #(
   parameter int          ADDR_W   = 8,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [31:0]       prog_wdata,
   input  logic [4:0]        dbg_sel,
   output logic [31:0]       dbg_reg,
   output logic [31:0]       PC,
   output logic [31:0]       IR,
   output logic [31:0]       ALUOut,
   output logic [31:0]       MDR,
   output logic [31:0]       A,
   output logic [31:0]       B,
   output logic [3:0]        state,
   output logic              halted,
   output logic              illegal,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int MEM_WORDS = 2 ** ADDR_W;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_REXEC    = 4'd6,
      S_RWB      = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IEXEC    = 4'd10,
      S_IWB      = 4'd11,
      S_HALT     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       alu_q, alu_d;
   logic [31:0]       mdr_q, mdr_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0]       rf_q  [32];
   logic [31:0]       mem_q [MEM_WORDS];

   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [31:0]       rf_wdata;
   logic              mem_we;
   logic              retire;
   logic [ADDR_W-1:0] mem_raddr;
   logic [31:0]       mem_rdata;

   logic [5:0]        opcode;
   logic [4:0]        rs, rt, rd;
   logic [5:0]        funct;
   logic [31:0]       imm_sext;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

   // Only FETCH and MEMREAD consume read data; upper address bits wrap.
   assign mem_raddr = (state_q == S_FETCH) ? pc_q[ADDR_W+1:2] : alu_q[ADDR_W+1:2];
   assign mem_rdata = mem_q[mem_raddr];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      a_d       = a_q;
      b_d       = b_q;
      illegal_d = illegal_q;
      rf_we     = 1'b0;
      rf_waddr  = 5'd0;
      rf_wdata  = 32'h0;
      mem_we    = 1'b0;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + 32'd4;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            a_d   = rf_q[rs];
            b_d   = rf_q[rt];
            alu_d = pc_q + {imm_sext[29:0], 2'b00};
            case (opcode)
               OP_RTYPE:     state_d = S_REXEC;
               OP_LW, OP_SW: state_d = S_MEMADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_IEXEC;
               OP_HALT:      state_d = S_HALT;
               default: begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADDR: begin
            alu_d   = a_q + imm_sext;
            state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mdr_d   = mem_rdata;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = mdr_q;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_we  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_REXEC: begin
            state_d = S_RWB;
            case (funct)
               6'h20:   alu_d = a_q + b_q;
               6'h22:   alu_d = a_q - b_q;
               6'h24:   alu_d = a_q & b_q;
               6'h25:   alu_d = a_q | b_q;
               6'h2A:   alu_d = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
               default: begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_RWB: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = alu_q;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            if (a_q == b_q) pc_d = alu_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_IEXEC: begin
            alu_d   = a_q + imm_sext;
            state_d = S_IWB;
         end
         S_IWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = alu_q;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
      cnt_d = (retire && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= 32'h0;
         alu_q     <= 32'h0;
         mdr_q     <= 32'h0;
         a_q       <= 32'h0;
         b_q       <= 32'h0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         alu_q     <= alu_d;
         mdr_q     <= mdr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
         // Register 0 stays at its reset value of zero.
         if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
      end
   end

   // Memory has no reset; the load port is only live while the core is held in reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         if (prog_we) mem_q[prog_addr] <= prog_wdata;
      end else if (mem_we) begin
         mem_q[alu_q[ADDR_W+1:2]] <= b_q;
      end
   end

   assign dbg_reg     = (dbg_sel == 5'd0) ? 32'h0 : rf_q[dbg_sel];
   assign PC          = pc_q;
   assign IR          = ir_q;
   assign ALUOut      = alu_q;
   assign MDR         = mdr_q;
   assign A           = a_q;
   assign B           = b_q;
   assign state       = state_q;
   assign halted      = (state_q == S_HALT);
   assign illegal     = illegal_q;
   assign instr_count = cnt_q;

endmodule
